// File: rtl/stopwatch_pkg.sv
// Shared command and state encodings for the stopwatch time base.
package stopwatch_pkg;

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_HOLD  = 2'b10;
  localparam logic [1:0] CMD_LAP   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider: counts 0..DIV-1 while ce is high, pulses tick_o on the wrapping cycle.
module tick_prescaler #(
  parameter int DIV = 10,
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic hard_reset,
  input  logic clr,
  input  logic ce,
  output logic tick_o
);

  logic [PW-1:0] r_cnt;

  // Combinational so the owner can update its fields on the very edge the count wraps.
  assign tick_o = ce && (r_cnt == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (hard_reset || clr) begin
      r_cnt <= '0;
    end else if (ce) begin
      r_cnt <= tick_o ? '0 : r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/stopwatch_timer.sv
// Stopwatch time base: run/hold/clear/lap command FSM over cascaded frac/sec/min fields.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_FREQ = 100,
  parameter int MIN_MAX   = 59,
  parameter int SATURATE  = 0,
  localparam int DIV = CLK_FREQ / TICK_FREQ,
  localparam int FW  = $clog2(TICK_FREQ),
  localparam int MW  = $clog2(MIN_MAX + 1)
) (
  input  logic          clk,
  input  logic          hard_reset,
  input  logic [1:0]    en,
  output logic [FW-1:0] frac,
  output logic [5:0]    sec,
  output logic [MW-1:0] min,
  output logic [FW-1:0] lap_frac,
  output logic [5:0]    lap_sec,
  output logic [MW-1:0] lap_min,
  output logic          lap_valid,
  output logic          tick,
  output logic          ovf,
  output logic [1:0]    state
);

  state_t        r_state;
  logic [FW-1:0] r_frac;
  logic [5:0]    r_sec;
  logic [MW-1:0] r_min;
  logic [FW-1:0] r_lap_frac;
  logic [5:0]    r_lap_sec;
  logic [MW-1:0] r_lap_min;
  logic          r_lap_valid;
  logic          r_tick;
  logic          r_ovf;

  logic w_clr;
  logic w_ce;
  logic w_inc;
  logic w_at_max;

  assign w_clr    = (en == CMD_CLEAR);
  assign w_ce     = (r_state == ST_RUN);
  assign w_at_max = (r_frac == FW'(TICK_FREQ - 1)) && (r_sec == 6'd59) &&
                    (r_min == MW'(MIN_MAX));

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk        (clk),
    .hard_reset (hard_reset),
    .clr        (w_clr),
    .ce         (w_ce),
    .tick_o     (w_inc)
  );

  always_ff @(posedge clk) begin
    if (hard_reset) begin
      r_state     <= ST_IDLE;
      r_frac      <= '0;
      r_sec       <= '0;
      r_min       <= '0;
      r_lap_frac  <= '0;
      r_lap_sec   <= '0;
      r_lap_min   <= '0;
      r_lap_valid <= 1'b0;
      r_tick      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (en)
        CMD_CLEAR: begin
          r_state     <= ST_IDLE;
          r_frac      <= '0;
          r_sec       <= '0;
          r_min       <= '0;
          r_lap_frac  <= '0;
          r_lap_sec   <= '0;
          r_lap_min   <= '0;
          r_lap_valid <= 1'b0;
          r_ovf       <= 1'b0;
        end
        CMD_RUN:  r_state <= ST_RUN;
        CMD_HOLD: r_state <= ST_HOLD;
        CMD_LAP: begin
          // Non-blocking reads give the pre-increment value when a tick lands on this edge.
          r_lap_frac  <= r_frac;
          r_lap_sec   <= r_sec;
          r_lap_min   <= r_min;
          r_lap_valid <= 1'b1;
        end
      endcase

      if (!w_clr && w_inc) begin
        if (w_at_max) begin
          r_ovf <= 1'b1;
          if (SATURATE == 0) begin
            r_frac <= '0;
            r_sec  <= '0;
            r_min  <= '0;
            r_tick <= 1'b1;
          end
        end else begin
          r_tick <= 1'b1;
          if (r_frac == FW'(TICK_FREQ - 1)) begin
            r_frac <= '0;
            if (r_sec == 6'd59) begin
              r_sec <= '0;
              r_min <= r_min + MW'(1);
            end else begin
              r_sec <= r_sec + 6'd1;
            end
          end else begin
            r_frac <= r_frac + FW'(1);
          end
        end
      end
    end
  end

  assign frac      = r_frac;
  assign sec       = r_sec;
  assign min       = r_min;
  assign lap_frac  = r_lap_frac;
  assign lap_sec   = r_lap_sec;
  assign lap_min   = r_lap_min;
  assign lap_valid = r_lap_valid;
  assign tick      = r_tick;
  assign ovf       = r_ovf;
  assign state     = r_state;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Bench for stopwatch_timer: one DUT at DIV=10 for command timing, two at DIV=2 for wrap and saturation.
module tb_stopwatch_timer;
  import stopwatch_pkg::*;

  localparam int SW = 33;

  logic       clk = 1'b0;
  logic       hard_reset;
  logic [1:0] en_a;
  logic [1:0] en_w;

  logic [6:0] a_frac, a_lfrac, w_frac, w_lfrac, s_frac, s_lfrac;
  logic [5:0] a_sec, a_lsec, w_sec, w_lsec, s_sec, s_lsec;
  logic       a_min, a_lmin, w_min, w_lmin, s_min, s_lmin;
  logic       a_lv, a_tick, a_ovf, w_lv, w_tick, w_ovf, s_lv, s_tick, s_ovf;
  logic [1:0] a_state, w_state, s_state;

  logic [SW+1:0] exp_q[$];
  string         name_q[$];
  logic [6:0]    tick_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic s_watch  = 1'b0;
  logic done     = 1'b0;

  logic [SW+1:0] m_exp;
  logic [SW-1:0] m_act;
  string         m_name;
  logic [6:0]    m_tfrac;

  always #10 clk = ~clk;

  stopwatch_timer #(.CLK_FREQ(1000), .TICK_FREQ(100), .MIN_MAX(1), .SATURATE(0)) dut_a (
    .clk(clk), .hard_reset(hard_reset), .en(en_a),
    .frac(a_frac), .sec(a_sec), .min(a_min),
    .lap_frac(a_lfrac), .lap_sec(a_lsec), .lap_min(a_lmin), .lap_valid(a_lv),
    .tick(a_tick), .ovf(a_ovf), .state(a_state));

  stopwatch_timer #(.CLK_FREQ(200), .TICK_FREQ(100), .MIN_MAX(1), .SATURATE(0)) dut_w (
    .clk(clk), .hard_reset(hard_reset), .en(en_w),
    .frac(w_frac), .sec(w_sec), .min(w_min),
    .lap_frac(w_lfrac), .lap_sec(w_lsec), .lap_min(w_lmin), .lap_valid(w_lv),
    .tick(w_tick), .ovf(w_ovf), .state(w_state));

  stopwatch_timer #(.CLK_FREQ(200), .TICK_FREQ(100), .MIN_MAX(1), .SATURATE(1)) dut_s (
    .clk(clk), .hard_reset(hard_reset), .en(en_w),
    .frac(s_frac), .sec(s_sec), .min(s_min),
    .lap_frac(s_lfrac), .lap_sec(s_lsec), .lap_min(s_lmin), .lap_valid(s_lv),
    .tick(s_tick), .ovf(s_ovf), .state(s_state));

  function automatic logic [SW-1:0] snap(input logic [1:0] st, input logic ov, input logic lv,
                                         input logic tk, input logic mn, input logic [5:0] sc,
                                         input logic [6:0] fr, input logic lmn,
                                         input logic [5:0] lsc, input logic [6:0] lfr);
    return {st, ov, lv, tk, mn, sc, fr, lmn, lsc, lfr};
  endfunction

  function automatic string fmt(input logic [SW-1:0] v);
    return $sformatf("st=%0d ovf=%0d lv=%0d tick=%0d t=%0d:%0d.%0d lap=%0d:%0d.%0d",
                     v[32:31], v[30], v[29], v[28], v[27], v[26:21], v[20:14],
                     v[13], v[12:7], v[6:0]);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_snap(input logic [1:0] sel, input string name, input logic [SW-1:0] v);
    exp_q.push_back({sel, v});
    name_q.push_back(name);
  endtask

  task automatic expect_ticks(input int first, input int last);
    for (int i = first; i <= last; i++) tick_q.push_back(7'(i));
  endtask

  // Scoreboard/monitor: drains snapshot expectations, checks every dut_a tick, watches saturation.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_exp  = exp_q.pop_front();
      m_name = name_q.pop_front();
      case (m_exp[SW+1:SW])
        2'd0:    m_act = {a_state, a_ovf, a_lv, a_tick, a_min, a_sec, a_frac, a_lmin, a_lsec, a_lfrac};
        2'd1:    m_act = {w_state, w_ovf, w_lv, w_tick, w_min, w_sec, w_frac, w_lmin, w_lsec, w_lfrac};
        default: m_act = {s_state, s_ovf, s_lv, s_tick, s_min, s_sec, s_frac, s_lmin, s_lsec, s_lfrac};
      endcase
      n_checks++;
      if (m_act !== m_exp[SW-1:0]) begin
        n_fail++;
        $display("FAIL %s: got %s, expected %s", m_name, fmt(m_act), fmt(m_exp[SW-1:0]));
      end
    end
    if (a_tick === 1'b1) begin
      n_checks++;
      if (tick_q.size() == 0) begin
        n_fail++;
        $display("FAIL a_tick: got unexpected tick at frac=%0d, expected no tick", a_frac);
      end else begin
        m_tfrac = tick_q.pop_front();
        if (a_frac !== m_tfrac) begin
          n_fail++;
          $display("FAIL a_tick_frac: got frac=%0d, expected frac=%0d", a_frac, m_tfrac);
        end
      end
    end
    if (s_watch) begin
      n_checks++;
      if (s_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_tick: got tick=%0b, expected 0 while saturated", s_tick);
      end
    end
    if (done) begin
      n_checks++;
      if (tick_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_ticks: got %0d ticks outstanding, expected 0", tick_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    hard_reset = 1'b1;
    en_a = CMD_RUN;
    en_w = CMD_CLEAR;
    step(2);
    expect_snap(0, "reset_a", snap(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    expect_snap(1, "reset_w", snap(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    expect_snap(2, "reset_s", snap(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    hard_reset = 1'b0;
    expect_ticks(1, 2);
    en_a = CMD_RUN;
    step(25);
    expect_snap(0, "run25", snap(ST_RUN, 0, 0, 0, 0, 0, 2, 0, 0, 0));

    en_a = CMD_CLEAR;
    step(1);
    expect_snap(0, "clear1", snap(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    expect_ticks(1, 3);
    en_a = CMD_RUN;
    step(34);
    expect_snap(0, "run34", snap(ST_RUN, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    en_a = CMD_HOLD;
    step(50);
    expect_snap(0, "hold50", snap(ST_HOLD, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    expect_ticks(4, 4);
    en_a = CMD_RUN;
    step(6);
    expect_snap(0, "resume6", snap(ST_RUN, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    step(1);
    expect_snap(0, "resume7", snap(ST_RUN, 0, 0, 1, 0, 0, 4, 0, 0, 0));

    en_a = CMD_CLEAR;
    step(1);
    expect_snap(0, "clear2", snap(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    expect_ticks(1, 5);
    en_a = CMD_RUN;
    step(51);
    expect_snap(0, "run_to_05", snap(ST_RUN, 0, 0, 1, 0, 0, 5, 0, 0, 0));
    en_a = CMD_LAP;
    step(1);
    expect_snap(0, "lap_05", snap(ST_RUN, 0, 1, 0, 0, 0, 5, 0, 0, 5));
    expect_ticks(6, 7);
    en_a = CMD_RUN;
    step(9);
    expect_snap(0, "after_lap", snap(ST_RUN, 0, 1, 1, 0, 0, 6, 0, 0, 5));
    step(9);
    en_a = CMD_LAP;
    step(1);
    expect_snap(0, "lap_on_tick", snap(ST_RUN, 0, 1, 1, 0, 0, 7, 0, 0, 6));

    en_a = CMD_CLEAR;
    step(1);
    expect_snap(0, "clear_lap", snap(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    expect_ticks(1, 1);
    en_a = CMD_RUN;
    step(15);
    expect_snap(0, "run15", snap(ST_RUN, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    hard_reset = 1'b1;
    step(1);
    expect_snap(0, "reset_mid_run", snap(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    hard_reset = 1'b0;
    en_a = CMD_HOLD;
    step(20);
    expect_snap(0, "hold_from_idle", snap(ST_HOLD, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    en_w = CMD_RUN;
    step(199);
    expect_snap(1, "w_0_00_99", snap(ST_RUN, 0, 0, 1, 0, 0, 99, 0, 0, 0));
    expect_snap(2, "s_0_00_99", snap(ST_RUN, 0, 0, 1, 0, 0, 99, 0, 0, 0));
    step(2);
    expect_snap(1, "w_0_01_00", snap(ST_RUN, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    step(11798);
    expect_snap(1, "w_0_59_99", snap(ST_RUN, 0, 0, 1, 0, 59, 99, 0, 0, 0));
    step(2);
    expect_snap(1, "w_1_00_00", snap(ST_RUN, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    step(11998);
    expect_snap(1, "w_1_59_99", snap(ST_RUN, 0, 0, 1, 1, 59, 99, 0, 0, 0));
    expect_snap(2, "s_1_59_99", snap(ST_RUN, 0, 0, 1, 1, 59, 99, 0, 0, 0));
    step(2);
    expect_snap(1, "w_wrap", snap(ST_RUN, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    expect_snap(2, "s_saturate", snap(ST_RUN, 1, 0, 0, 1, 59, 99, 0, 0, 0));
    s_watch = 1'b1;
    step(10);
    s_watch = 1'b0;
    expect_snap(1, "w_after_wrap", snap(ST_RUN, 1, 0, 1, 0, 0, 5, 0, 0, 0));
    expect_snap(2, "s_held", snap(ST_RUN, 1, 0, 0, 1, 59, 99, 0, 0, 0));

    en_w = CMD_CLEAR;
    step(1);
    expect_snap(1, "w_clear_ovf", snap(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    expect_snap(2, "s_clear_ovf", snap(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    done = 1'b1;
  end

endmodule
